ritc_idelay_eye_scan: RTL

//  Automatic per-bit IDELAY eye scanner for the RITC inputs. Sits upstream of the IDELAY control path and drives its delay/address/load interface.
//  For one selected bit it steps all 32 taps and counts mismatches between the sampled bit and the expected training bit at each tap.
//  It finds the longest error-free tap run, then loads the run centre into the bit. Results go back to the register interface.

---
 rtl/ritc_idelay_eye_scan.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ritc_idelay_eye_scan.sv
// Per-bit IDELAY eye scanner: sweeps all taps of one RITC input, measures the
// longest error-free tap run against the training pattern and loads its centre.
module ritc_idelay_eye_scan #(
    parameter int DELAY_W       = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64,
    parameter int ERRCNT_W      = 8
) (
    input  logic               CLK,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [1:0]         chan_i,
    input  logic [3:0]         bit_i,
    input  logic               sample_i,
    input  logic               expect_i,
    input  logic               valid_i,
    input  logic [2:0]         ready_i,
    output logic [DELAY_W-1:0] delay_o,
    output logic [5:0]         addr_o,
    output logic               load_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [DELAY_W-1:0] eye_start_o,
    output logic [DELAY_W:0]   eye_width_o,
    output logic [DELAY_W-1:0] center_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SMP_W-1:0]    SAMPLE_LAST = SMP_W'(SAMPLE_CYCLES - 1);
    localparam logic [DELAY_W-1:0]  TAP_ZERO    = {DELAY_W{1'b0}};
    localparam logic [DELAY_W-1:0]  TAP_LAST    = {DELAY_W{1'b1}};
    localparam logic [DELAY_W:0]    LEN_ZERO    = {(DELAY_W+1){1'b0}};
    localparam logic [DELAY_W:0]    LEN_ONE     = (DELAY_W+1)'(1);
    localparam logic [ERRCNT_W-1:0] ERR_ZERO    = {ERRCNT_W{1'b0}};
    localparam logic [ERRCNT_W-1:0] ERR_MAX     = {ERRCNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_EVAL   = 3'd5,
        ST_FINAL  = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          chan_r, chan_s;
    logic [3:0]          bit_r, bit_s;
    logic [DELAY_W-1:0]  tap_r, tap_s;
    logic [SET_W-1:0]    set_cnt_r, set_cnt_s;
    logic [SMP_W-1:0]    smp_cnt_r, smp_cnt_s;
    logic [ERRCNT_W-1:0] errcnt_r, errcnt_s;
    logic [DELAY_W:0]    run_len_r, run_len_s;
    logic [DELAY_W-1:0]  run_start_r, run_start_s;
    logic [DELAY_W:0]    best_len_r, best_len_s;
    logic [DELAY_W-1:0]  best_start_r, best_start_s;
    logic                err_r, err_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                load_r, load_s;
    logic [DELAY_W-1:0]  delay_r, delay_s;
    logic [5:0]          addr_r, addr_s;
    logic [DELAY_W-1:0]  eye_start_r, eye_start_s;
    logic [DELAY_W:0]    eye_width_r, eye_width_s;
    logic [DELAY_W-1:0]  center_r, center_s;

    logic                ready_sel_s;
    logic                target_bad_s;
    logic                abort_s;
    logic                good_s;
    logic [DELAY_W:0]    run_len_next_s;
    logic [DELAY_W-1:0]  run_start_next_s;
    logic [DELAY_W-1:0]  centre_calc_s;

    // Select the IDELAYCTRL ready of the latched channel
    always_comb begin
        case (chan_r)
            2'd0:    ready_sel_s = ready_i[0];
            2'd1:    ready_sel_s = ready_i[1];
            2'd2:    ready_sel_s = ready_i[2];
            default: ready_sel_s = 1'b0;
        endcase
    end

    // 4'hF is the channel clock delay, so only 12..14 are holes in the bit map
    assign target_bad_s     = (chan_r == 2'd3) || ((bit_r >= 4'd12) && (bit_r != 4'hF));
    assign abort_s          = (state_r inside {ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_EVAL}) && !ready_sel_s;
    assign good_s           = (errcnt_r == ERR_ZERO);
    assign run_len_next_s   = good_s ? (run_len_r + 1'b1) : LEN_ZERO;
    assign run_start_next_s = (good_s && (run_len_r == LEN_ZERO)) ? tap_r : run_start_r;
    assign centre_calc_s    = best_start_r + DELAY_W'((best_len_r - LEN_ONE) >> 1);

    // FSM state register
    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; losing ready mid-sweep always wins
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   if (start_i) state_s = ST_CHECK; else state_s = ST_IDLE;
            ST_CHECK:  if (target_bad_s) state_s = ST_DONE;
                       else if (ready_sel_s) state_s = ST_LOAD;
                       else state_s = ST_CHECK;
            ST_LOAD:   if (abort_s) state_s = ST_DONE; else state_s = ST_SETTLE;
            ST_SETTLE: if (abort_s) state_s = ST_DONE;
                       else if (set_cnt_r == SETTLE_LAST) state_s = ST_SAMPLE;
                       else state_s = ST_SETTLE;
            ST_SAMPLE: if (abort_s) state_s = ST_DONE;
                       else if (valid_i && (smp_cnt_r == SAMPLE_LAST)) state_s = ST_EVAL;
                       else state_s = ST_SAMPLE;
            ST_EVAL:   if (abort_s) state_s = ST_DONE;
                       else if (tap_r == TAP_LAST) state_s = ST_FINAL;
                       else state_s = ST_LOAD;
            ST_FINAL:  state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM output and datapath next values
    always_comb begin
        chan_s       = chan_r;
        bit_s        = bit_r;
        tap_s        = tap_r;
        set_cnt_s    = set_cnt_r;
        smp_cnt_s    = smp_cnt_r;
        errcnt_s     = errcnt_r;
        run_len_s    = run_len_r;
        run_start_s  = run_start_r;
        best_len_s   = best_len_r;
        best_start_s = best_start_r;
        err_s        = err_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        load_s       = 1'b0;
        delay_s      = delay_r;
        addr_s       = addr_r;
        eye_start_s  = eye_start_r;
        eye_width_s  = eye_width_r;
        center_s     = center_r;
        if (abort_s) begin
            err_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        chan_s       = chan_i;
                        bit_s        = bit_i;
                        addr_s       = {chan_i, bit_i};
                        busy_s       = 1'b1;
                        err_s        = 1'b0;
                        eye_start_s  = TAP_ZERO;
                        eye_width_s  = LEN_ZERO;
                        center_s     = TAP_ZERO;
                        run_len_s    = LEN_ZERO;
                        run_start_s  = TAP_ZERO;
                        best_len_s   = LEN_ZERO;
                        best_start_s = TAP_ZERO;
                    end else begin
                        busy_s = busy_r;
                    end
                end
                ST_CHECK: begin
                    if (target_bad_s) err_s = 1'b1;
                    else if (ready_sel_s) tap_s = TAP_ZERO;
                    else tap_s = tap_r;
                end
                ST_LOAD: begin
                    load_s    = 1'b1;
                    delay_s   = tap_r;
                    set_cnt_s = {SET_W{1'b0}};
                end
                ST_SETTLE: begin
                    if (set_cnt_r == SETTLE_LAST) begin
                        errcnt_s  = ERR_ZERO;
                        smp_cnt_s = {SMP_W{1'b0}};
                    end else begin
                        set_cnt_s = set_cnt_r + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (valid_i) begin
                        smp_cnt_s = smp_cnt_r + 1'b1;
                        if ((sample_i != expect_i) && (errcnt_r != ERR_MAX)) errcnt_s = errcnt_r + 1'b1;
                        else errcnt_s = errcnt_r;
                    end else begin
                        smp_cnt_s = smp_cnt_r;
                    end
                end
                ST_EVAL: begin
                    run_len_s   = run_len_next_s;
                    run_start_s = run_start_next_s;
                    // Strict compare keeps the earliest of equal-length runs
                    if (run_len_next_s > best_len_r) begin
                        best_len_s   = run_len_next_s;
                        best_start_s = run_start_next_s;
                    end else begin
                        best_len_s   = best_len_r;
                    end
                    if (tap_r != TAP_LAST) tap_s = tap_r + 1'b1;
                    else tap_s = tap_r;
                end
                ST_FINAL: begin
                    if (best_len_r == LEN_ZERO) begin
                        err_s = 1'b1;
                    end else begin
                        load_s  = 1'b1;
                        delay_s = centre_calc_s;
                    end
                end
                ST_DONE: begin
                    done_s = 1'b1;
                    busy_s = 1'b0;
                    if (err_r) begin
                        eye_start_s = TAP_ZERO;
                        eye_width_s = LEN_ZERO;
                        center_s    = TAP_ZERO;
                    end else begin
                        eye_start_s = best_start_r;
                        eye_width_s = best_len_r;
                        center_s    = centre_calc_s;
                    end
                end
                default: done_s = 1'b0;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chan_r       <= 2'd0;
            bit_r        <= 4'd0;
            tap_r        <= TAP_ZERO;
            set_cnt_r    <= {SET_W{1'b0}};
            smp_cnt_r    <= {SMP_W{1'b0}};
            errcnt_r     <= ERR_ZERO;
            run_len_r    <= LEN_ZERO;
            run_start_r  <= TAP_ZERO;
            best_len_r   <= LEN_ZERO;
            best_start_r <= TAP_ZERO;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            load_r       <= 1'b0;
            delay_r      <= TAP_ZERO;
            addr_r       <= 6'd0;
            eye_start_r  <= TAP_ZERO;
            eye_width_r  <= LEN_ZERO;
            center_r     <= TAP_ZERO;
        end else begin
            chan_r       <= chan_s;
            bit_r        <= bit_s;
            tap_r        <= tap_s;
            set_cnt_r    <= set_cnt_s;
            smp_cnt_r    <= smp_cnt_s;
            errcnt_r     <= errcnt_s;
            run_len_r    <= run_len_s;
            run_start_r  <= run_start_s;
            best_len_r   <= best_len_s;
            best_start_r <= best_start_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            load_r       <= load_s;
            delay_r      <= delay_s;
            addr_r       <= addr_s;
            eye_start_r  <= eye_start_s;
            eye_width_r  <= eye_width_s;
            center_r     <= center_s;
        end
    end

    assign delay_o     = delay_r;
    assign addr_o      = addr_r;
    assign load_o      = load_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign eye_start_o = eye_start_r;
    assign eye_width_o = eye_width_r;
    assign center_o    = center_r;

endmodule
